maxpool_stream: RTL and testbench

- Streaming 1-D max-pool stage directly downstream of the convolution layer (conv_<X>_<F>_<T>_<P>).
- Consumes the conv y stream (valid/ready, signed T-bit, one frame of N = SIZE_X-SIZE_F+1 points) and emits one signed maximum per non-overlapping window of W samples.
- Feeds the next layer through the same valid/ready convention. A single-entry output register carries backpressure upstream.

---
 rtl/maxpool_stream.sv | 74 +++++++
 tb/tb_maxpool_stream.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// Streaming signed 1-D max-pool: one maximum per W-sample window, N-sample frames back-to-back.
// One-cycle latency; a single output register stalls x_ready. Optional y_last port under MAXPOOL_LAST_EN.
module maxpool_stream #(
    parameter int T = 16,
    parameter int N = 32,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [T-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready
`ifdef MAXPOOL_LAST_EN
    ,
    output logic         y_last
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (W > 1) ? $clog2(W) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(N - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(W - 1);

    logic [T-1:0]  acc;
    logic [PW-1:0] pos_cnt;
    logic [WW-1:0] win_cnt;
    logic          in_xfer;
    logic          pos_end;
    logic          close;
    logic [T-1:0]  cand;

    // Ready depends only on the output register, never on x_valid.
    assign x_ready = !(y_valid && !y_ready);
    assign in_xfer = x_valid && x_ready;
    assign pos_end = (pos_cnt == POS_LAST);
    assign close   = (win_cnt == WIN_LAST) || pos_end;
    assign cand    = ((win_cnt == '0) || ($signed(x_data) > $signed(acc))) ? x_data : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            pos_cnt <= '0;
            win_cnt <= '0;
            y_data  <= '0;
            y_valid <= 1'b0;
`ifdef MAXPOOL_LAST_EN
            y_last  <= 1'b0;
`endif
        end else begin
            if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end
            if (in_xfer) begin
                // A closing window overrides the drain above, giving bubble-free output.
                if (close) begin
                    y_data  <= cand;
                    y_valid <= 1'b1;
                    win_cnt <= '0;
`ifdef MAXPOOL_LAST_EN
                    y_last  <= pos_end;
`endif
                end else begin
                    acc     <= cand;
                    win_cnt <= win_cnt + 1'b1;
                end
                pos_cnt <= pos_end ? '0 : pos_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: three instances (N/W = 32/2, 5/2, 8/1) checked against a window-max model.
module tb_maxpool_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] xd[3];
    logic        xv[3];
    logic        xr[3];
    logic [15:0] yd[3];
    logic        yv[3];
    logic        yr[3];
`ifdef MAXPOOL_LAST_EN
    logic        yl[3];
`endif

    int pn[3] = '{32, 5, 8};
    int pw[3] = '{2, 2, 1};

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int xr_low;
    int samp[$];
    int exp_d[$];
    bit exp_l[$];
    int got_d[$];
    int got_t[$];
    bit got_l[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    maxpool_stream #(.T(16), .N(32), .W(2)) u_a (
        .clk(clk), .reset(reset), .x_data(xd[0]), .x_valid(xv[0]), .x_ready(xr[0]),
        .y_data(yd[0]), .y_valid(yv[0]), .y_ready(yr[0])
`ifdef MAXPOOL_LAST_EN
        , .y_last(yl[0])
`endif
    );

    maxpool_stream #(.T(16), .N(5), .W(2)) u_b (
        .clk(clk), .reset(reset), .x_data(xd[1]), .x_valid(xv[1]), .x_ready(xr[1]),
        .y_data(yd[1]), .y_valid(yv[1]), .y_ready(yr[1])
`ifdef MAXPOOL_LAST_EN
        , .y_last(yl[1])
`endif
    );

    maxpool_stream #(.T(16), .N(8), .W(1)) u_c (
        .clk(clk), .reset(reset), .x_data(xd[2]), .x_valid(xv[2]), .x_ready(xr[2]),
        .y_data(yd[2]), .y_valid(yv[2]), .y_ready(yr[2])
`ifdef MAXPOOL_LAST_EN
        , .y_last(yl[2])
`endif
    );

    // Reference: split the stream into frames of N, each frame into W-wide slices, take each slice's max.
    function automatic void build_expected(input int idx);
        int n, w, we, m;
        n = pn[idx];
        w = pw[idx];
        exp_d.delete();
        exp_l.delete();
        for (int base = 0; base < samp.size(); base += n) begin
            for (int ws = 0; ws < n; ws += w) begin
                we = (ws + w < n) ? ws + w : n;
                if (base + we <= samp.size()) begin
                    m = samp[base + ws];
                    for (int k = base + ws + 1; k < base + we; k++)
                        if (samp[k] > m) m = samp[k];
                    exp_d.push_back(m);
                    exp_l.push_back(we == n);
                end
            end
        end
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            xv[i] = 1'b0;
            yr[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input int gap_pct);
        for (int i = 0; i < samp.size(); i++) begin
            bit took;
            int guard;
            took = 1'b0;
            guard = 0;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                xv[idx] = 1'b0;
                @(posedge clk);
                #1;
            end
            xv[idx] = 1'b1;
            xd[idx] = 16'(samp[i]);
            while (!took && guard < 2000) begin
                @(negedge clk);
                took = xr[idx];
                @(posedge clk);
                #1;
                guard++;
            end
        end
        xv[idx] = 1'b0;
    endtask

    task automatic collect(input int idx, input int nexp, input int budget, input int yr_pct);
        int v;
        got_d.delete();
        got_t.delete();
        got_l.delete();
        xr_low = 0;
        for (int c = 0; c < budget && got_d.size() < nexp; c++) begin
            yr[idx] = (yr_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < yr_pct);
            @(negedge clk);
            if (!xr[idx]) xr_low++;
            if (yv[idx] && yr[idx]) begin
                v = $signed(yd[idx]);
                got_d.push_back(v);
                got_t.push_back(cyc);
`ifdef MAXPOOL_LAST_EN
                got_l.push_back(yl[idx]);
`else
                got_l.push_back(1'b0);
`endif
            end
            @(posedge clk);
            #1;
        end
        yr[idx] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (yv[i] !== 1'b0) $display("FAIL reset_y_valid[%0d]: got %b want 0", i, yv[i]);
            else pass_cnt++;
            total_cnt++;
            if (yd[i] !== 16'h0) $display("FAIL reset_y_data[%0d]: got %h want 0000", i, yd[i]);
            else pass_cnt++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (xr[i] !== 1'b1) $display("FAIL reset_x_ready[%0d]: got %b want 1", i, xr[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ramp();
        apply_reset();
        samp.delete();
        for (int i = 1; i <= 32; i++) samp.push_back(i);
        build_expected(0);
        fork
            drive(0, 0);
            collect(0, 16, 200, 100);
        join
        total_cnt++;
        if (got_d.size() != 16) $display("FAIL ramp_count: got %0d want 16", got_d.size());
        else pass_cnt++;
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            total_cnt++;
            if (got_d[k] !== exp_d[k]) $display("FAIL ramp_data[%0d]: got %0d want %0d", k, got_d[k], exp_d[k]);
            else pass_cnt++;
`ifdef MAXPOOL_LAST_EN
            total_cnt++;
            if (got_l[k] !== exp_l[k]) $display("FAIL ramp_last[%0d]: got %b want %b", k, got_l[k], exp_l[k]);
            else pass_cnt++;
`endif
        end
        for (int k = 1; k < got_t.size(); k++) begin
            total_cnt++;
            if (got_t[k] - got_t[k-1] != 2)
                $display("FAIL ramp_spacing[%0d]: got %0d cycles want 2", k, got_t[k] - got_t[k-1]);
            else pass_cnt++;
        end
        total_cnt++;
        if (xr_low != 0) $display("FAIL ramp_x_ready_drop: got %0d low cycles want 0", xr_low);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        apply_reset();
        samp = '{-5, -3, -7, 0, 32767, -32768};
        build_expected(0);
        fork
            drive(0, 0);
            collect(0, 3, 100, 100);
        join
        total_cnt++;
        if (got_d.size() != 3) $display("FAIL signed_count: got %0d want 3", got_d.size());
        else pass_cnt++;
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            total_cnt++;
            if (got_d[k] !== exp_d[k]) $display("FAIL signed_data[%0d]: got %0d want %0d", k, got_d[k], exp_d[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_partial();
        apply_reset();
        samp = '{4, 9, -2, -8, 6, 1, 1, 1, 1, 1};
        build_expected(1);
        fork
            drive(1, 0);
            collect(1, 6, 100, 100);
        join
        total_cnt++;
        if (got_d.size() != 6) $display("FAIL partial_count: got %0d want 6", got_d.size());
        else pass_cnt++;
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            total_cnt++;
            if (got_d[k] !== exp_d[k]) $display("FAIL partial_data[%0d]: got %0d want %0d", k, got_d[k], exp_d[k]);
            else pass_cnt++;
`ifdef MAXPOOL_LAST_EN
            total_cnt++;
            if (got_l[k] !== exp_l[k]) $display("FAIL partial_last[%0d]: got %b want %b", k, got_l[k], exp_l[k]);
            else pass_cnt++;
`endif
        end
        // Closes fall on samples 2 and 10: eight cycles apart when frames run with no gap.
        if (got_t.size() == 6) begin
            total_cnt++;
            if (got_t[5] - got_t[0] != 8) $display("FAIL partial_span: got %0d cycles want 8", got_t[5] - got_t[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int bad;
        apply_reset();
        samp.delete();
        for (int i = 1; i <= 32; i++) samp.push_back(i);
        build_expected(0);
        yr[0] = 1'b0;
        fork
            drive(0, 0);
            begin
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (yv[0]) break;
                end
                total_cnt++;
                if (yv[0] !== 1'b1) $display("FAIL bp_first_valid: got %b want 1", yv[0]);
                else pass_cnt++;
                total_cnt++;
                if (yd[0] !== 16'd2) $display("FAIL bp_first_data: got %0d want 2", yd[0]);
                else pass_cnt++;
                total_cnt++;
                if (xr[0] !== 1'b0) $display("FAIL bp_x_ready: got %b want 0", xr[0]);
                else pass_cnt++;
                bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (yd[0] !== 16'd2 || yv[0] !== 1'b1 || xr[0] !== 1'b0) bad++;
                end
                total_cnt++;
                if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
                else pass_cnt++;
                @(posedge clk);
                #1;
                collect(0, 16, 300, 100);
            end
        join
        total_cnt++;
        if (got_d.size() != 16) $display("FAIL bp_count: got %0d want 16", got_d.size());
        else pass_cnt++;
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            total_cnt++;
            if (got_d[k] !== exp_d[k]) $display("FAIL bp_data[%0d]: got %0d want %0d", k, got_d[k], exp_d[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        samp = '{3, 7, 5};
        build_expected(2);
        fork
            drive(2, 0);
            collect(2, 3, 50, 100);
        join
        total_cnt++;
        if (got_d.size() != 3) $display("FAIL b2b_count: got %0d want 3", got_d.size());
        else pass_cnt++;
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            total_cnt++;
            if (got_d[k] !== exp_d[k]) $display("FAIL b2b_data[%0d]: got %0d want %0d", k, got_d[k], exp_d[k]);
            else pass_cnt++;
        end
        for (int k = 1; k < got_t.size(); k++) begin
            total_cnt++;
            if (got_t[k] - got_t[k-1] != 1)
                $display("FAIL b2b_spacing[%0d]: got %0d cycles want 1", k, got_t[k] - got_t[k-1]);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (yv[2] !== 1'b0) $display("FAIL b2b_drain: got y_valid %b want 0", yv[2]);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        yr[1] = 1'b0;
        xv[1] = 1'b1;
        xd[1] = 16'd4;
        @(posedge clk);
        #1;
        xd[1] = 16'd9;
        @(posedge clk);
        #1;
        xd[1] = 16'hFFFE;
        @(negedge clk);
        total_cnt++;
        if (yv[1] !== 1'b1 || yd[1] !== 16'd9) $display("FAIL mid_pending: got v=%b d=%0d want v=1 d=9", yv[1], yd[1]);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        xv[1] = 1'b0;
        total_cnt++;
        if (yv[1] !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", yv[1]);
        else pass_cnt++;
        total_cnt++;
        if (xr[1] !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", xr[1]);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        yr[1] = 1'b1;
        @(posedge clk);
        #1;
        samp = '{10, 20, 30, 40, 50};
        build_expected(1);
        fork
            drive(1, 0);
            collect(1, 3, 60, 100);
        join
        total_cnt++;
        if (got_d.size() != 3) $display("FAIL mid_count: got %0d want 3", got_d.size());
        else pass_cnt++;
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            total_cnt++;
            if (got_d[k] !== exp_d[k]) $display("FAIL mid_data[%0d]: got %0d want %0d", k, got_d[k], exp_d[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int nout[2] = '{48, 12};
        int nin[2] = '{96, 20};
        for (int r = 0; r < 2; r++) begin
            apply_reset();
            samp.delete();
            for (int i = 0; i < nin[r]; i++) samp.push_back(int'($urandom_range(0, 65535)) - 32768);
            build_expected(r);
            fork
                drive(r, 30);
                collect(r, nout[r], 4000, 60);
            join
            total_cnt++;
            if (got_d.size() != exp_d.size())
                $display("FAIL rand%0d_count: got %0d want %0d", r, got_d.size(), exp_d.size());
            else pass_cnt++;
            for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
                total_cnt++;
                if (got_d[k] !== exp_d[k])
                    $display("FAIL rand%0d_data[%0d]: got %0d want %0d", r, k, got_d[k], exp_d[k]);
                else pass_cnt++;
`ifdef MAXPOOL_LAST_EN
                total_cnt++;
                if (got_l[k] !== exp_l[k])
                    $display("FAIL rand%0d_last[%0d]: got %b want %b", r, k, got_l[k], exp_l[k]);
                else pass_cnt++;
`endif
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            xv[i] = 1'b0;
            xd[i] = 16'h0;
            yr[i] = 1'b1;
        end
        test_reset();
        test_ramp();
        test_signed();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
